// File: rtl/float_mult_pipe_if.sv
// Operand/result handshake bundle for float_mult_pipe.
// master drives operands and out_ready; slave is the multiplier.
interface float_mult_pipe_if #(
    parameter int unsigned EXP_W = 4,
    parameter int unsigned MAN_W = 3
);
    localparam int unsigned W = 1 + EXP_W + MAN_W;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] float_a;
    logic [W-1:0] float_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] product;
    logic         out_ovf;
    logic         out_unf;

    modport master (
        output in_valid, float_a, float_b, out_ready,
        input  in_ready, out_valid, product, out_ovf, out_unf
    );

    modport slave (
        input  in_valid, float_a, float_b, out_ready,
        output in_ready, out_valid, product, out_ovf, out_unf
    );
endinterface

// File: rtl/float_mult_pipe.sv
// Three-stage pipelined minifloat multiplier: unpack, normalise/round (RNE), pack.
// Saturates on overflow, flushes to zero on underflow; one global advance enable.
module float_mult_pipe #(
    parameter int unsigned EXP_W = 4,
    parameter int unsigned MAN_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    float_mult_pipe_if.slave  bus
);
    localparam int unsigned W    = 1 + EXP_W + MAN_W;
    localparam int unsigned EW   = EXP_W + 2;
    localparam int unsigned PW   = 2 * MAN_W + 2;
    localparam int unsigned BIAS = (1 << (EXP_W - 1)) - 1;
    localparam int unsigned EMAX = (1 << EXP_W) - 1;

    localparam logic signed [EW-1:0] EMAX_S = EW'(EMAX);
    localparam logic signed [EW-1:0] EMIN_S = EW'(1);

    logic adv;

    // Stage 1 registers
    logic                 s1_valid;
    logic                 s1_zero;
    logic                 s1_sign;
    logic signed [EW-1:0] s1_exp;
    logic [PW-1:0]        s1_prod;

    // Stage 2 registers
    logic                 s2_valid;
    logic                 s2_zero;
    logic                 s2_sign;
    logic signed [EW-1:0] s2_exp;
    logic [MAN_W-1:0]     s2_man;

    // Unpacked operand fields
    logic             a_sign;
    logic             b_sign;
    logic [EXP_W-1:0] a_exp;
    logic [EXP_W-1:0] b_exp;
    logic [MAN_W-1:0] a_man;
    logic [MAN_W-1:0] b_man;

    logic                 unp_zero;
    logic                 unp_sign;
    logic signed [EW-1:0] unp_exp;
    logic [PW-1:0]        unp_prod;

    logic                 nrm_hi;
    logic [MAN_W-1:0]     nrm_man;
    logic                 nrm_guard;
    logic                 nrm_sticky;
    logic                 nrm_round;
    logic [MAN_W:0]       nrm_sum;
    logic signed [EW-1:0] nrm_exp;
    logic [MAN_W-1:0]     nrm_man_r;

    logic [W-1:0]         pack_prod;
    logic                 pack_ovf;
    logic                 pack_unf;

    assign adv         = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = adv;

    assign {a_sign, a_exp, a_man} = bus.float_a;
    assign {b_sign, b_exp, b_man} = bus.float_b;

    // Unpack: zero detect (denormals count as zero), biased exponent sum, significand product
    always_comb begin
        unp_zero = (a_exp == '0) || (b_exp == '0);
        unp_sign = a_sign ^ b_sign;
        unp_exp  = EW'(a_exp) + EW'(b_exp) - EW'(BIAS);
        unp_prod = PW'({1'b1, a_man}) * PW'({1'b1, b_man});
    end

    // Normalise the 2.x product and round to nearest even
    always_comb begin
        nrm_hi     = s1_prod[PW-1];
        nrm_man    = s1_prod[PW-3:MAN_W];
        nrm_guard  = s1_prod[MAN_W-1];
        nrm_sticky = |s1_prod[MAN_W-2:0];
        if (nrm_hi) begin
            nrm_man    = s1_prod[PW-2:MAN_W+1];
            nrm_guard  = s1_prod[MAN_W];
            nrm_sticky = |s1_prod[MAN_W-1:0];
        end
        nrm_round = nrm_guard && (nrm_sticky || nrm_man[0]);
        nrm_sum   = {1'b0, nrm_man} + (MAN_W+1)'(nrm_round);
        // A carry out of the mantissa leaves it all-zero and bumps the exponent
        nrm_exp   = s1_exp + EW'(nrm_hi) + EW'(nrm_sum[MAN_W]);
        nrm_man_r = nrm_sum[MAN_W-1:0];
    end

    // Pack with saturation and flush-to-zero; bubbles pack to zero
    always_comb begin
        pack_prod = '0;
        pack_ovf  = 1'b0;
        pack_unf  = 1'b0;
        if (!s2_valid || s2_zero) begin
            pack_prod = '0;
        end else if (s2_exp > EMAX_S) begin
            pack_prod = {s2_sign, {(W-1){1'b1}}};
            pack_ovf  = 1'b1;
        end else if (s2_exp < EMIN_S) begin
            pack_unf  = 1'b1;
        end else begin
            pack_prod = {s2_sign, s2_exp[EXP_W-1:0], s2_man};
        end
    end

    // Valid bits and the output register are reset; everything holds when stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid      <= 1'b0;
            s2_valid      <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.product   <= '0;
            bus.out_ovf   <= 1'b0;
            bus.out_unf   <= 1'b0;
        end else if (adv) begin
            s1_valid      <= bus.in_valid;
            s2_valid      <= s1_valid;
            bus.out_valid <= s2_valid;
            bus.product   <= pack_prod;
            bus.out_ovf   <= pack_ovf;
            bus.out_unf   <= pack_unf;
        end
    end

    // Non-reset datapath registers
    always_ff @(posedge clk) begin
        if (adv) begin
            s1_zero <= unp_zero;
            s1_sign <= unp_sign;
            s1_exp  <= unp_exp;
            s1_prod <= unp_prod;
            s2_zero <= s1_zero;
            s2_sign <= s1_sign;
            s2_exp  <= nrm_exp;
            s2_man  <= nrm_man_r;
        end
    end
endmodule
